// File: rtl/jt1942_prog_sdram.sv
// ROM download byte stream -> FIFO -> 16-bit masked SDRAM write requests (req/ack).
// Define JT1942_PROG_MERGE_EN to merge complementary byte pairs into one write.
module jt1942_prog_sdram #(
  parameter int FIFO_AW  = 3,
  parameter int MERGE_TO = 15
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic        wr_req,
  output logic [21:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_mask,
  input  logic        wr_ack,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 22 + 16 + 2;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} state_t;

  if (FIFO_AW < 1 || MERGE_TO < 1) begin : g_param_range_unsupported
  end

  state_t            state_q, state_d;
  logic              vld_p0_q, vld_p0_d;
  logic [21:0]       addr_p0_q, addr_p0_d;
  logic [7:0]        data_p0_q, data_p0_d;
  logic [1:0]        mask_p0_q, mask_p0_d;
  logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [EW-1:0]     head;
  logic [EW-1:0]     push_entry;
  logic              push_vld, push, pop, empty, full, hold_vld, drain_ok;
  logic              ovf_q, ovf_d, dl_q, dl_d, sess_q, sess_d;
  logic [21:0]       wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [1:0]        wr_mask_q, wr_mask_d;

  // p0: register the download strobe; bytes outside a session never enter
  always_comb begin
    vld_p0_d  = prog_we & downloading;
    addr_p0_d = prog_addr;
    data_p0_d = prog_data;
    mask_p0_d = prog_mask;
  end

`ifdef JT1942_PROG_MERGE_EN
  localparam int TO_W = (MERGE_TO > 1) ? $clog2(MERGE_TO) : 1;

  logic            vld_p1_q, vld_p1_d;
  logic [21:0]     addr_p1_q, addr_p1_d;
  logic [15:0]     data_p1_q, data_p1_d;
  logic [1:0]      mask_p1_q, mask_p1_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            pair;

  // p1: merge register; a held low/high byte waits for its partner
  always_comb begin
    vld_p1_d   = vld_p1_q;
    addr_p1_d  = addr_p1_q;
    data_p1_d  = data_p1_q;
    mask_p1_d  = mask_p1_q;
    to_cnt_d   = to_cnt_q;
    push_vld   = 1'b0;
    push_entry = {addr_p1_q, data_p1_q, mask_p1_q};
    pair = vld_p1_q && vld_p0_q && (addr_p0_q == addr_p1_q) &&
           (mask_p1_q == 2'b10 || mask_p1_q == 2'b01) &&
           ((mask_p0_q ^ mask_p1_q) == 2'b11);
    if (vld_p0_q) begin
      to_cnt_d = '0;
      if (pair) begin
        push_vld   = 1'b1;
        push_entry = {addr_p1_q,
                      (mask_p0_q == 2'b01) ? {data_p0_q, data_p1_q[7:0]}
                                           : {data_p1_q[15:8], data_p0_q},
                      2'b00};
        vld_p1_d   = 1'b0;
      end else begin
        push_vld  = vld_p1_q;
        vld_p1_d  = 1'b1;
        addr_p1_d = addr_p0_q;
        data_p1_d = {data_p0_q, data_p0_q};
        mask_p1_d = mask_p0_q;
      end
    end else if (vld_p1_q) begin
      if (to_cnt_q == TO_W'(MERGE_TO - 1) || !downloading) begin
        push_vld = 1'b1;
        vld_p1_d = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    hold_vld = vld_p1_q;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      to_cnt_q <= to_cnt_d;
    end
    addr_p1_q <= addr_p1_d;
    data_p1_q <= data_p1_d;
    mask_p1_q <= mask_p1_d;
  end
`else
  always_comb begin
    push_vld   = vld_p0_q;
    push_entry = {addr_p0_q, data_p0_q, data_p0_q, mask_p0_q};
    hold_vld   = 1'b0;
  end
`endif

  // FIFO: a pop in the same cycle frees the slot a push at full needs
  always_comb begin
    head  = mem_q[rptr_q[FIFO_AW-1:0]];
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
            (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    pop   = (state_q == REQ) && wr_ack;
    push  = push_vld && (!full || pop);
    mem_d = mem_q;
    if (push) mem_d[wptr_q[FIFO_AW-1:0]] = push_entry;
    wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
    rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
    dl_d   = downloading;
    ovf_d  = ovf_q;
    if (downloading && !dl_q) ovf_d = 1'b0;
    if (push_vld && full && !pop) ovf_d = 1'b1;
  end

  // Request FSM
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    drain_ok  = sess_q && !downloading && empty && !vld_p0_q && !hold_vld;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          wr_addr_d = head[39:18];
          wr_data_d = head[17:2];
          wr_mask_d = head[1:0];
          state_d   = REQ;
        end else if (drain_ok) begin
          state_d = DRAIN;
        end
      end
      REQ:     if (wr_ack) state_d = GAP;
      GAP:     state_d = drain_ok ? DRAIN : IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a session ends at its single done pulse
    sess_d = downloading ? 1'b1 : ((state_d == DRAIN) ? 1'b0 : sess_q);
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q   <= IDLE;
      vld_p0_q  <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      dl_q      <= 1'b0;
      sess_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= 2'b11;
    end else begin
      state_q   <= state_d;
      vld_p0_q  <= vld_p0_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      dl_q      <= dl_d;
      sess_q    <= sess_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
    end
    addr_p0_q <= addr_p0_d;
    data_p0_q <= data_p0_d;
    mask_p0_q <= mask_p0_d;
    mem_q     <= mem_d;
  end

  assign wr_req   = (state_q == REQ);
  assign done     = (state_q == DRAIN);
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_mask  = wr_mask_q;
  assign overflow = ovf_q;
  assign busy     = !empty || wr_req || hold_vld || vld_p0_q;

endmodule

// File: tb/tb_jt1942_prog_sdram.sv
// Directed bench for jt1942_prog_sdram: latency, FIFO full/overflow, ordering, drain and reset.
module tb_jt1942_prog_sdram;

  logic        clk_rom = 1'b0;
  logic        rst, downloading, prog_we;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        wr_req, wr_ack, busy, overflow, done;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        auto_ack, ack_man, ack_auto_r;

  int n_asrt = 0;
  int n_fail = 0;
  int rec_n = 0;
  int done_cnt = 0;
  int rec0, d0;
  logic [21:0] rec_addr [0:63];
  logic [15:0] rec_data [0:63];
  logic [1:0]  rec_mask [0:63];

  jt1942_prog_sdram dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_ack(wr_ack), .busy(busy), .overflow(overflow),
    .done(done)
  );

  always #5 clk_rom = ~clk_rom;

  initial ack_auto_r = 1'b0;
  always @(negedge clk_rom) ack_auto_r <= auto_ack && wr_req;
  assign wr_ack = ack_auto_r | ack_man;

  always @(posedge clk_rom) begin
    if (wr_req && wr_ack && !rst && rec_n < 64) begin
      rec_addr[rec_n] = wr_addr;
      rec_data[rec_n] = wr_data;
      rec_mask[rec_n] = wr_mask;
      rec_n++;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || wr_req) && k < 300) begin
      tick();
      k++;
    end
    check(tag, {62'd0, busy, wr_req}, 64'd0);
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt == base && k < 300) begin
      tick();
      k++;
    end
    check(tag, 64'(done_cnt != base), 64'd1);
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; prog_mask = 2'b11;
    auto_ack = 1'b0; ack_man = 1'b0;
    tick(); tick();
    check("rst_wr_req",   64'(wr_req),   64'd0);
    check("rst_wr_addr",  64'(wr_addr),  64'd0);
    check("rst_wr_data",  64'(wr_data),  64'd0);
    check("rst_wr_mask",  64'(wr_mask),  64'd3);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done",     64'(done),     64'd0);
    rst = 1'b0;
    tick();

    // single byte: request appears two edges after the strobe edge
    downloading = 1'b1;
    tick();
    rec0 = rec_n;
    put(22'h0A000, 8'h5A, 2'b10);
    check("lat_e0", 64'(wr_req), 64'd0);
    tick();
    check("lat_e1", 64'(wr_req), 64'd0);
    tick();
    check("lat_e2_req",  64'(wr_req),  64'd1);
    check("single_addr", 64'(wr_addr), 64'h0A000);
    check("single_data", 64'(wr_data), 64'h5A5A);
    check("single_mask", 64'(wr_mask), 64'd2);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("gap_req0", 64'(wr_req), 64'd0);
    tick();
    check("gap_req1", 64'(wr_req), 64'd0);
    check("single_cnt",  64'(rec_n - rec0), 64'd1);
    check("single_busy", 64'(busy), 64'd0);

    // burst of 8 fills the FIFO; the 9th is dropped
    rec0 = rec_n;
    for (int i = 0; i < 8; i++)
      put(22'h100 + 22'(i), 8'h10 + 8'(i), (i % 2 == 1) ? 2'b01 : 2'b10);
    put(22'h1FF, 8'hEE, 2'b10);
    check("full_ovf0", 64'(overflow), 64'd0);
    tick();
    check("full_ovf1",  64'(overflow), 64'd1);
    check("full_req",   64'(wr_req),   64'd1);
    check("full_head",  64'(wr_addr),  64'h100);
    auto_ack = 1'b1;
    wait_idle("burst_idle");
    check("burst_cnt", 64'(rec_n - rec0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_addr%0d", i), 64'(rec_addr[rec0 + i]), 64'(22'h100 + i));
      check($sformatf("burst_data%0d", i), 64'(rec_data[rec0 + i]),
            64'({8'h10 + 8'(i), 8'h10 + 8'(i)}));
    end
    auto_ack = 1'b0;

    // overflow is sticky through the session end, cleared when a new one starts
    d0 = done_cnt;
    downloading = 1'b0;
    wait_done(d0, "ovf_sess_done");
    check("ovf_sticky", 64'(overflow), 64'd1);
    downloading = 1'b1;
    tick();
    check("ovf_cleared", 64'(overflow), 64'd0);

    // push at full accepted when the same edge pops
    rec0 = rec_n;
    for (int i = 0; i < 9; i++) put(22'h200 + 22'(i), 8'h20 + 8'(i), 2'b10);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("fullack_ovf", 64'(overflow), 64'd0);
    check("fullack_pop", 64'(rec_n - rec0), 64'd1);
    auto_ack = 1'b1;
    wait_idle("fullack_idle");
    check("fullack_cnt",   64'(rec_n - rec0), 64'd9);
    check("fullack_addr8", 64'(rec_addr[rec0 + 8]), 64'h208);
    check("fullack_data8", 64'(rec_data[rec0 + 8]), 64'h2828);
    check("fullack_ovf2",  64'(overflow), 64'd0);
    auto_ack = 1'b0;

    // downloading falls with 3 queued: serve them, then one done pulse
    rec0 = rec_n;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) put(22'h300 + 22'(i), 8'h30 + 8'(i), 2'b01);
    tick();
    downloading = 1'b0;
    auto_ack = 1'b1;
    wait_done(d0, "drain_done_seen");
    repeat (5) tick();
    check("drain_done_once", 64'(done_cnt - d0), 64'd1);
    check("drain_cnt",       64'(rec_n - rec0), 64'd3);
    check("drain_mask2",     64'(rec_mask[rec0 + 2]), 64'd1);
    check("drain_busy",      64'(busy), 64'd0);
    auto_ack = 1'b0;

    // zero-write session still gives exactly one done
    d0 = done_cnt;
    downloading = 1'b1;
    tick(); tick();
    downloading = 1'b0;
    repeat (6) tick();
    check("empty_sess_done", 64'(done_cnt - d0), 64'd1);

    // reset with a request outstanding; the ack in the reset cycle is ignored
    downloading = 1'b1;
    tick();
    d0 = done_cnt;
    rec0 = rec_n;
    put(22'h3FFFFF, 8'hA5, 2'b10);
    tick(); tick();
    check("rstreq_pre", 64'(wr_req), 64'd1);
    rst = 1'b1;
    ack_man = 1'b1;
    tick();
    rst = 1'b0;
    ack_man = 1'b0;
    check("rstreq_req",  64'(wr_req),  64'd0);
    check("rstreq_busy", 64'(busy),    64'd0);
    check("rstreq_mask", 64'(wr_mask), 64'd3);
    repeat (5) tick();
    check("rstreq_nodone", 64'(done_cnt - d0), 64'd0);
    check("rstreq_nowr",   64'(rec_n - rec0),  64'd0);
    check("rstreq_idle",   64'(wr_req),        64'd0);

`ifdef JT1942_PROG_MERGE_EN
    // complementary pair at one address becomes one full-word write
    auto_ack = 1'b1;
    rec0 = rec_n;
    put(22'h15000, 8'h12, 2'b10);
    put(22'h15000, 8'h34, 2'b01);
    wait_idle("merge_idle");
    check("merge_cnt",  64'(rec_n - rec0), 64'd1);
    check("merge_data", 64'(rec_data[rec0]), 64'h3412);
    check("merge_mask", 64'(rec_mask[rec0]), 64'd0);
    rec0 = rec_n;
    put(22'h15001, 8'h56, 2'b10);
    repeat (10) tick();
    check("lone_held", 64'(rec_n - rec0), 64'd0);
    repeat (20) tick();
    check("lone_flush", 64'(rec_n - rec0), 64'd1);
    auto_ack = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
